// File: rtl/bsg_manycore_accel_pkg.sv
// Constants shared by the stream feeder and the accelerator tile, plus the
// manycore packet layout macros used to build the endpoint packet struct.
`ifndef BSG_MANYCORE_PACKET_VH
`define BSG_MANYCORE_PACKET_VH

`define BSG_MANYCORE_PACKET_WIDTH(addr_width_mp, data_width_mp, x_cord_width_mp, y_cord_width_mp) \
  (6 + (addr_width_mp) + (data_width_mp) + 2*((x_cord_width_mp) + (y_cord_width_mp)))

`define DECLARE_BSG_MANYCORE_PACKET_S(addr_width_mp, data_width_mp, x_cord_width_mp, y_cord_width_mp) \
  typedef struct packed { \
    logic [(addr_width_mp)-1:0]   addr; \
    logic [1:0]                   op; \
    logic [3:0]                   op_ex; \
    logic [(data_width_mp)-1:0]   data; \
    logic [(y_cord_width_mp)-1:0] src_y_cord; \
    logic [(x_cord_width_mp)-1:0] src_x_cord; \
    logic [(y_cord_width_mp)-1:0] y_cord; \
    logic [(x_cord_width_mp)-1:0] x_cord; \
  } bsg_manycore_packet_s

`endif

package bsg_manycore_accel_pkg;

  // Word offsets of the accelerator register window.
  localparam int unsigned accel_addr_reg = 0;
  localparam int unsigned accel_dest_reg = 1;
  localparam int unsigned accel_fwd_reg  = 2;

  localparam logic [1:0] op_store    = 2'b01;
  localparam logic [3:0] op_ex_store = 4'b1111;

  typedef enum logic [2:0] {
    e_idle,
    e_cfg_addr,
    e_cfg_dest,
    e_stream,
    e_drain
  } feeder_state_e;

endpackage

// File: rtl/bsg_manycore_accel_feeder_counter.sv
// Loadable down-counter with a zero flag; saturates at zero so a stray
// decrement can never wrap the remaining-word count.
module bsg_manycore_accel_feeder_counter
  #(parameter int width_p = 16)
  (input  logic               clk_i
  , input  logic               reset_i
  , input  logic               load_i
  , input  logic [width_p-1:0] load_val_i
  , input  logic               dec_i
  , output logic [width_p-1:0] count_o
  , output logic               zero_o
  );

  logic [width_p-1:0] count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_r <= '0;
    else if (load_i)
      count_r <= load_val_i;
    else if (dec_i && !zero_o)
      count_r <= count_r - width_p'(1);
  end

  assign count_o = count_r;
  assign zero_o  = (count_r == '0);

endmodule

// File: rtl/bsg_manycore_accel_stream_feeder.sv
// Feeds one accelerator tile: two config stores, then len data stores, then
// waits for every credit to come home before signalling done.
//
//   state       | meaning
//   e_idle      | ready for a command
//   e_cfg_addr  | storing forward address to accel offset 0
//   e_cfg_dest  | storing forward destination {y,x} to accel offset 1
//   e_stream    | storing stream words to accel offset 2
//   e_drain     | waiting for all credits to return (fence)
module bsg_manycore_accel_stream_feeder
  import bsg_manycore_accel_pkg::*;
  #(parameter int x_cord_width_p    = 4
  , parameter int y_cord_width_p    = 4
  , parameter int data_width_p      = 32
  , parameter int addr_width_p      = 12
  , parameter int max_out_credits_p = 4
  , parameter int len_width_p       = 16
  , parameter int accel_base_addr_p = 0
  , localparam int packet_width_lp  = `BSG_MANYCORE_PACKET_WIDTH(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
  , localparam int credit_width_lp  = $clog2(max_out_credits_p+1)
  )
  (input  logic                       clk_i
  , input  logic                       reset_i
  , input  logic [x_cord_width_p-1:0]  my_x_i
  , input  logic [y_cord_width_p-1:0]  my_y_i
  , input  logic                       cmd_v_i
  , output logic                       cmd_ready_o
  , input  logic [x_cord_width_p-1:0]  cmd_accel_x_i
  , input  logic [y_cord_width_p-1:0]  cmd_accel_y_i
  , input  logic [addr_width_p-1:0]    cmd_fwd_addr_i
  , input  logic [x_cord_width_p-1:0]  cmd_fwd_x_i
  , input  logic [y_cord_width_p-1:0]  cmd_fwd_y_i
  , input  logic [len_width_p-1:0]     cmd_len_i
  , input  logic                       data_v_i
  , input  logic [data_width_p-1:0]    data_i
  , output logic                       data_yumi_o
  , output logic [packet_width_lp-1:0] out_packet_o
  , output logic                       out_v_o
  , input  logic                       out_ready_i
  , input  logic [credit_width_lp-1:0] out_credits_i
  , output logic                       done_o
  );

  `DECLARE_BSG_MANYCORE_PACKET_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

  localparam logic [addr_width_p-1:0] base_lp = addr_width_p'(accel_base_addr_p);

  feeder_state_e state_r, state_n;

  logic [x_cord_width_p-1:0] accel_x_r, fwd_x_r;
  logic [y_cord_width_p-1:0] accel_y_r, fwd_y_r;
  logic [addr_width_p-1:0]   fwd_addr_r;

  logic                      load_cmd, dec;
  logic [len_width_p-1:0]    count;
  logic                      count_zero;
  logic                      credits_nz, credits_full;
  logic [addr_width_p-1:0]   pkt_addr;
  logic [data_width_p-1:0]   pkt_data;
  bsg_manycore_packet_s      pkt;

  assign credits_nz   = (out_credits_i != '0);
  assign credits_full = (out_credits_i == credit_width_lp'(max_out_credits_p));

  bsg_manycore_accel_feeder_counter #(.width_p(len_width_p)) counter (
    .clk_i      (clk_i)
    ,.reset_i    (reset_i)
    ,.load_i     (load_cmd)
    ,.load_val_i (cmd_len_i)
    ,.dec_i      (dec)
    ,.count_o    (count)
    ,.zero_o     (count_zero)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      accel_x_r  <= '0;
      accel_y_r  <= '0;
      fwd_addr_r <= '0;
      fwd_x_r    <= '0;
      fwd_y_r    <= '0;
    end else begin
      state_r <= state_n;
      if (load_cmd) begin
        accel_x_r  <= cmd_accel_x_i;
        accel_y_r  <= cmd_accel_y_i;
        fwd_addr_r <= cmd_fwd_addr_i;
        fwd_x_r    <= cmd_fwd_x_i;
        fwd_y_r    <= cmd_fwd_y_i;
      end
    end
  end

  // out_v_o is built only from state, credits and data_v_i so the endpoint
  // can derive ready from valid without a combinational loop.
  always_comb begin
    state_n     = state_r;
    cmd_ready_o = 1'b0;
    out_v_o     = 1'b0;
    data_yumi_o = 1'b0;
    done_o      = 1'b0;
    load_cmd    = 1'b0;
    dec         = 1'b0;
    pkt_addr    = base_lp + addr_width_p'(accel_addr_reg);
    pkt_data    = '0;

    unique case (state_r)
      e_idle: begin
        cmd_ready_o = 1'b1;
        if (cmd_v_i) begin
          load_cmd = 1'b1;
          state_n  = e_cfg_addr;
        end
      end
      e_cfg_addr: begin
        out_v_o  = credits_nz;
        pkt_data = data_width_p'(fwd_addr_r);
        if (out_v_o && out_ready_i)
          state_n = e_cfg_dest;
      end
      e_cfg_dest: begin
        out_v_o  = credits_nz;
        pkt_addr = base_lp + addr_width_p'(accel_dest_reg);
        pkt_data = data_width_p'({fwd_y_r, fwd_x_r});
        if (out_v_o && out_ready_i)
          state_n = count_zero ? e_drain : e_stream;
      end
      e_stream: begin
        out_v_o  = data_v_i && credits_nz;
        pkt_addr = base_lp + addr_width_p'(accel_fwd_reg);
        pkt_data = data_i;
        if (out_v_o && out_ready_i) begin
          data_yumi_o = 1'b1;
          dec         = 1'b1;
          if (count == len_width_p'(1))
            state_n = e_drain;
        end
      end
      e_drain: begin
        if (credits_full) begin
          done_o  = 1'b1;
          state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  assign pkt.addr       = pkt_addr;
  assign pkt.op         = op_store;
  assign pkt.op_ex      = op_ex_store;
  assign pkt.data       = pkt_data;
  assign pkt.src_y_cord = my_y_i;
  assign pkt.src_x_cord = my_x_i;
  assign pkt.y_cord     = accel_y_r;
  assign pkt.x_cord     = accel_x_r;

  assign out_packet_o = pkt;

endmodule

// File: tb/tb_bsg_manycore_accel_stream_feeder.sv
// Directed bench for the accelerator stream feeder: expected packets are
// queued when a command is issued and popped as the feeder sends them.
module tb_bsg_manycore_accel_stream_feeder;

  localparam int XW = 4, YW = 4, DW = 32, AW = 12, MC = 4, LW = 16, BASE = 'h100;
  localparam int PW = 6 + AW + DW + 2*(XW + YW);
  localparam int CW = $clog2(MC+1);
  localparam logic [XW-1:0] MY_X = 4'd3;
  localparam logic [YW-1:0] MY_Y = 4'd5;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          cmd_v_i, cmd_ready_o;
  logic [XW-1:0] cmd_accel_x_i, cmd_fwd_x_i;
  logic [YW-1:0] cmd_accel_y_i, cmd_fwd_y_i;
  logic [AW-1:0] cmd_fwd_addr_i;
  logic [LW-1:0] cmd_len_i;
  logic          data_v_i, data_yumi_o;
  logic [DW-1:0] data_i;
  logic [PW-1:0] out_packet_o;
  logic          out_v_o, out_ready_i, done_o;
  logic [CW-1:0] out_credits_i;

  always #5 clk = ~clk;

  bsg_manycore_accel_stream_feeder #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .addr_width_p(AW)
    ,.max_out_credits_p(MC), .len_width_p(LW), .accel_base_addr_p(BASE)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .my_x_i(MY_X), .my_y_i(MY_Y)
    ,.cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o)
    ,.cmd_accel_x_i(cmd_accel_x_i), .cmd_accel_y_i(cmd_accel_y_i)
    ,.cmd_fwd_addr_i(cmd_fwd_addr_i), .cmd_fwd_x_i(cmd_fwd_x_i), .cmd_fwd_y_i(cmd_fwd_y_i)
    ,.cmd_len_i(cmd_len_i), .data_v_i(data_v_i), .data_i(data_i), .data_yumi_o(data_yumi_o)
    ,.out_packet_o(out_packet_o), .out_v_o(out_v_o), .out_ready_i(out_ready_i)
    ,.out_credits_i(out_credits_i), .done_o(done_o)
  );

  logic [PW-1:0] exp_q[$];
  logic [DW-1:0] dq[$];
  int errors = 0, checks = 0;
  int sent_cnt = 0, yumi_cnt = 0, done_cnt = 0;
  bit last_sent, last_yumi, last_done, last_acc, last_v, last_ready;
  logic [PW-1:0] last_pkt, front;
  bit auto_ret = 1'b1, data_en = 1'b1;
  int s0, y0, bad;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic [XW-1:0] ax, input logic [YW-1:0] ay);
    return {a, 2'b01, 4'b1111, d, MY_Y, MY_X, ay, ax};
  endfunction

  task automatic drive_data();
    data_v_i = data_en && (dq.size() != 0);
    data_i   = (dq.size() != 0) ? dq[0] : '0;
  endtask

  // Observe at the falling edge, then update endpoint credits and the data
  // source just after the rising edge.
  task automatic tick();
    logic [CW-1:0] c;
    @(negedge clk);
    last_v     = out_v_o;
    last_pkt   = out_packet_o;
    last_sent  = out_v_o & out_ready_i;
    last_yumi  = data_yumi_o;
    last_done  = done_o;
    last_ready = cmd_ready_o;
    last_acc   = cmd_v_i & cmd_ready_o;
    check("yumi_without_send", 128'(last_yumi & ~last_sent), 128'(0));
    if (last_sent) begin
      check("packet_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        check("packet", 128'(out_packet_o), 128'(e));
      end
      sent_cnt++;
    end
    if (last_yumi) yumi_cnt++;
    if (last_done) done_cnt++;
    @(posedge clk);
    #1;
    c = out_credits_i;
    if (last_sent) c = c - CW'(1);
    if (auto_ret && out_credits_i < CW'(MC)) c = c + CW'(1);
    out_credits_i = c;
    if (last_yumi && dq.size() != 0) void'(dq.pop_front());
    drive_data();
  endtask

  task automatic issue(input logic [XW-1:0] ax, input logic [YW-1:0] ay, input logic [AW-1:0] fa,
                       input logic [XW-1:0] fx, input logic [YW-1:0] fy, input int len,
                       input logic [DW-1:0] seed);
    cmd_accel_x_i  = ax;
    cmd_accel_y_i  = ay;
    cmd_fwd_addr_i = fa;
    cmd_fwd_x_i    = fx;
    cmd_fwd_y_i    = fy;
    cmd_len_i      = LW'(len);
    cmd_v_i        = 1'b1;
    exp_q.push_back(mk(AW'(BASE + 0), DW'(fa), ax, ay));
    exp_q.push_back(mk(AW'(BASE + 1), DW'({fy, fx}), ax, ay));
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] w;
      w = seed + DW'(i);
      dq.push_back(w);
      exp_q.push_back(mk(AW'(BASE + 2), w, ax, ay));
    end
    drive_data();
  endtask

  task automatic wait_accept(input int limit);
    int n = 0;
    do begin tick(); n++; end while (!last_acc && n < limit);
    check("cmd_accepted", 128'(last_acc), 128'(1));
    cmd_v_i = 1'b0;
  endtask

  task automatic wait_sends(input int target, input int limit);
    int n = 0;
    while (sent_cnt < target && n < limit) begin tick(); n++; end
    check("sends_reached", 128'(sent_cnt >= target), 128'(1));
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < limit) begin tick(); n++; end
    check("done_seen", 128'(done_cnt != d0), 128'(1));
  endtask

  initial begin
    reset_i = 1'b1; cmd_v_i = 1'b0; cmd_len_i = '0;
    cmd_accel_x_i = '0; cmd_accel_y_i = '0; cmd_fwd_addr_i = '0; cmd_fwd_x_i = '0; cmd_fwd_y_i = '0;
    data_v_i = 1'b0; data_i = '0; out_ready_i = 1'b1; out_credits_i = CW'(MC);

    // reset state
    repeat (3) tick();
    check("rst_cmd_ready", 128'(last_ready), 128'(1));
    check("rst_out_v", 128'(last_v), 128'(0));
    check("rst_yumi", 128'(last_yumi), 128'(0));
    check("rst_done", 128'(last_done), 128'(0));
    reset_i = 1'b0;

    // basic command, len=3
    y0 = yumi_cnt;
    issue(4'd0, 4'd1, 12'h040, 4'd2, 4'd1, 3, 32'hD000_0000);
    wait_accept(10);
    wait_done(50);
    check("t1_all_packets", 128'(exp_q.size()), 128'(0));
    check("t1_yumis", 128'(yumi_cnt - y0), 128'(3));
    tick();
    check("t1_done_one_cycle", 128'(last_done), 128'(0));
    check("t1_ready_after_done", 128'(last_ready), 128'(1));

    // len=0: config stores only
    s0 = sent_cnt; y0 = yumi_cnt;
    issue(4'd7, 4'd2, 12'hABC, 4'd9, 4'd6, 0, 32'h0);
    wait_accept(10);
    wait_done(50);
    check("t2_sends", 128'(sent_cnt - s0), 128'(2));
    check("t2_yumis", 128'(yumi_cnt - y0), 128'(0));

    // no credits during stream stalls the feeder
    auto_ret = 1'b0;
    s0 = sent_cnt;
    issue(4'd1, 4'd1, 12'h123, 4'd4, 4'd3, 2, 32'hA500_0000);
    wait_accept(10);
    wait_sends(s0 + 2, 20);
    out_credits_i = '0;
    bad = 0;
    repeat (3) begin tick(); bad += int'(last_v) + int'(last_yumi); end
    check("t3_stall_no_credit", 128'(bad), 128'(0));
    out_credits_i = CW'(1);
    tick();
    check("t3_one_credit_send", 128'(last_sent), 128'(1));
    check("t3_one_credit_yumi", 128'(last_yumi), 128'(1));
    tick();
    check("t3_credit_spent", 128'(last_v), 128'(0));
    auto_ret = 1'b1;
    wait_done(50);
    check("t3_all_packets", 128'(exp_q.size()), 128'(0));

    // endpoint back-pressure holds the packet steady
    s0 = sent_cnt; y0 = yumi_cnt;
    issue(4'd2, 4'd3, 12'h0F0, 4'd5, 4'd7, 2, 32'hBEEF_0000);
    wait_accept(10);
    wait_sends(s0 + 2, 20);
    out_ready_i = 1'b0;
    front = exp_q[0];
    repeat (5) begin
      tick();
      check("t4_out_v_held", 128'(last_v), 128'(1));
      check("t4_packet_stable", 128'(last_pkt), 128'(front));
      check("t4_no_yumi", 128'(last_yumi), 128'(0));
    end
    out_ready_i = 1'b1;
    wait_done(50);
    check("t4_yumis", 128'(yumi_cnt - y0), 128'(2));

    // late credit return delays done; held command waits for the fence
    auto_ret = 1'b0;
    s0 = sent_cnt;
    issue(4'd3, 4'd2, 12'h777, 4'd1, 4'd1, 2, 32'hC000_0010);
    wait_accept(10);
    issue(4'd6, 4'd0, 12'h555, 4'd2, 4'd2, 1, 32'hE000_0000);
    wait_sends(s0 + 4, 20);
    bad = 0;
    repeat (10) begin tick(); bad += int'(last_done) + int'(last_acc); end
    check("t5_no_early_done", 128'(bad), 128'(0));
    out_credits_i = CW'(MC);
    auto_ret = 1'b1;
    tick();
    check("t5_done_on_full", 128'(last_done), 128'(1));
    check("t5_no_accept_with_done", 128'(last_acc), 128'(0));
    tick();
    check("t5_accept_after_done", 128'(last_acc), 128'(1));
    cmd_v_i = 1'b0;
    wait_done(50);
    check("t5_all_packets", 128'(exp_q.size()), 128'(0));

    // reset in the middle of a stream
    data_en = 1'b0;
    s0 = sent_cnt;
    issue(4'd5, 4'd5, 12'h321, 4'd3, 4'd4, 4, 32'hF000_0000);
    wait_accept(10);
    wait_sends(s0 + 2, 20);
    data_en = 1'b1;
    drive_data();
    tick();
    check("t6_first_word", 128'(last_yumi), 128'(1));
    data_en = 1'b0;
    drive_data();
    reset_i = 1'b1;
    tick();
    tick();
    check("t6_idle_ready", 128'(last_ready), 128'(1));
    check("t6_idle_out_v", 128'(last_v), 128'(0));
    reset_i = 1'b0;
    exp_q.delete();
    dq.delete();
    data_en = 1'b1;
    issue(4'd1, 4'd2, 12'h0AA, 4'd6, 4'd5, 1, 32'h1234_5678);
    wait_accept(10);
    wait_done(50);
    check("t6_restart_packets", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
